// File: rtl/clefia_sbox_layer.sv
// CLEFIA S-box layer: two-stage valid/ready pipeline applying S0 or S1 per byte lane.
// Stage 1 holds the incoming word and select; stage 2 holds the substituted word.

module clefia_s0 (
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);
    localparam logic [3:0] SS0 [16] = '{4'hE, 4'h6, 4'hC, 4'hA, 4'h8, 4'h7, 4'h2, 4'hF,
                                       4'hB, 4'h1, 4'h4, 4'h0, 4'h5, 4'h9, 4'hD, 4'h3};
    localparam logic [3:0] SS1 [16] = '{4'h6, 4'h4, 4'h0, 4'hD, 4'h2, 4'hB, 4'hA, 4'h3,
                                       4'h9, 4'hC, 4'hE, 4'hF, 4'h8, 4'h7, 4'h5, 4'h1};
    localparam logic [3:0] SS2 [16] = '{4'hB, 4'h8, 4'h5, 4'hE, 4'hA, 4'h6, 4'h4, 4'hC,
                                       4'hF, 4'h7, 4'h2, 4'h3, 4'h1, 4'h0, 4'hD, 4'h9};
    localparam logic [3:0] SS3 [16] = '{4'hA, 4'h2, 4'h6, 4'hD, 4'h3, 4'h4, 4'h5, 4'hE,
                                       4'h0, 4'h7, 4'h8, 4'h9, 4'hB, 4'hF, 4'hC, 4'h1};

    // Multiply by 0x2 in GF(2^4) modulo z^4 + z + 1.
    function automatic logic [3:0] mul2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    logic [3:0] t0, t1, u0, u1;

    always_comb begin
        t0  = SS0[x_i[7:4]];
        t1  = SS1[x_i[3:0]];
        u0  = t0 ^ mul2(t1);
        u1  = mul2(t0) ^ t1;
        y_o = {SS2[u0], SS3[u1]};
    end
endmodule

module clefia_s1 (
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);
    localparam logic [7:0] S1_TAB [256] = '{
        8'h6c, 8'hda, 8'hc3, 8'he9, 8'h4e, 8'h9d, 8'h0a, 8'h3d, 8'hb8, 8'h36, 8'hb4, 8'h38, 8'h13, 8'h34, 8'h0c, 8'hd9,
        8'hbf, 8'h74, 8'h94, 8'h8f, 8'hb7, 8'h9c, 8'he5, 8'hdc, 8'h9e, 8'h07, 8'h49, 8'h4f, 8'h98, 8'h2c, 8'hb0, 8'h93,
        8'h12, 8'heb, 8'hcd, 8'hb3, 8'h92, 8'he7, 8'h41, 8'h60, 8'he3, 8'h21, 8'h27, 8'h3b, 8'he6, 8'h19, 8'hd2, 8'h0e,
        8'h91, 8'h11, 8'hc7, 8'h3f, 8'h2a, 8'h8e, 8'ha1, 8'hbc, 8'h2b, 8'hc8, 8'hc5, 8'h0f, 8'h5b, 8'hf3, 8'h87, 8'h8b,
        8'hfb, 8'hf5, 8'hde, 8'h20, 8'hc6, 8'ha7, 8'h84, 8'hce, 8'hd8, 8'h65, 8'h51, 8'hc9, 8'ha4, 8'hef, 8'h43, 8'h53,
        8'h25, 8'h5d, 8'h9b, 8'h31, 8'he8, 8'h3e, 8'h0d, 8'hd7, 8'h80, 8'hff, 8'h69, 8'h8a, 8'hba, 8'h0b, 8'h73, 8'h5c,
        8'h6e, 8'h54, 8'h15, 8'h62, 8'hf6, 8'h35, 8'h30, 8'h52, 8'ha3, 8'h16, 8'hd3, 8'h28, 8'h32, 8'hfa, 8'haa, 8'h5e,
        8'hcf, 8'hea, 8'hed, 8'h78, 8'h33, 8'h58, 8'h09, 8'h7b, 8'h63, 8'hc0, 8'hc1, 8'h46, 8'h1e, 8'hdf, 8'ha9, 8'h99,
        8'h55, 8'h04, 8'hc4, 8'h86, 8'h39, 8'h77, 8'h82, 8'hec, 8'h40, 8'h18, 8'h90, 8'h97, 8'h59, 8'hdd, 8'h83, 8'h1f,
        8'h9a, 8'h37, 8'h06, 8'h24, 8'h64, 8'h7c, 8'ha5, 8'h56, 8'h48, 8'h08, 8'h85, 8'hd0, 8'h61, 8'h26, 8'hca, 8'h6f,
        8'h7e, 8'h6a, 8'hb6, 8'h71, 8'ha0, 8'h70, 8'h05, 8'hd1, 8'h45, 8'h8c, 8'h23, 8'h1c, 8'hf0, 8'hee, 8'h89, 8'had,
        8'h7a, 8'h4b, 8'hc2, 8'h2f, 8'hdb, 8'h5a, 8'h4d, 8'h76, 8'h67, 8'h17, 8'h2d, 8'hf4, 8'hcb, 8'hb1, 8'h4a, 8'ha8,
        8'hb5, 8'h22, 8'h47, 8'h3a, 8'hd5, 8'h10, 8'h4c, 8'h72, 8'hcc, 8'h00, 8'hf9, 8'he0, 8'hfd, 8'he2, 8'hfe, 8'hae,
        8'hf8, 8'h5f, 8'hab, 8'hf1, 8'h1b, 8'h42, 8'h81, 8'hd6, 8'hbe, 8'h44, 8'h29, 8'ha6, 8'h57, 8'hb9, 8'haf, 8'hf2,
        8'hd4, 8'h75, 8'h66, 8'hbb, 8'h68, 8'h9f, 8'h50, 8'h02, 8'h01, 8'h3c, 8'h7f, 8'h8d, 8'h1a, 8'h88, 8'hbd, 8'hac,
        8'hf7, 8'he4, 8'h79, 8'h96, 8'ha2, 8'hfc, 8'h6d, 8'hb2, 8'h6b, 8'h03, 8'he1, 8'h2e, 8'h7d, 8'h14, 8'h95, 8'h1d
    };

    assign y_o = S1_TAB[x_i];
endmodule

module clefia_sbox_layer #(
    parameter int LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [8*LANES-1:0]   in_data_i,
    input  logic [LANES-1:0]     in_sel_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*LANES-1:0]   out_data_o,
    output logic [1:0]           occupancy_o
);
    localparam int W = 8 * LANES;

    logic             v1_q, v1_d, v2_q, v2_d;
    logic [W-1:0]     s1_data_q, s1_data_d;
    logic [LANES-1:0] s1_sel_q, s1_sel_d;
    logic [W-1:0]     s2_data_q, s2_data_d;
    logic [W-1:0]     lookup;
    logic             adv2, accept;

    // The select travels with its own word, so lane choice is taken from stage 1.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] s0_y, s1_y;

        clefia_s0 u_s0 (.x_i(s1_data_q[8*i +: 8]), .y_o(s0_y));
        clefia_s1 u_s1 (.x_i(s1_data_q[8*i +: 8]), .y_o(s1_y));

        assign lookup[8*i +: 8] = s1_sel_q[i] ? s1_y : s0_y;
    end

    always_comb begin
        adv2       = v1_q && (!v2_q || out_ready_i);
        in_ready_o = !rst_i && (!v1_q || adv2);
        accept     = in_valid_i && in_ready_o;
        v1_d       = accept || (v1_q && !adv2);
        v2_d       = adv2 || (v2_q && !out_ready_i);
        s1_data_d  = accept ? in_data_i : s1_data_q;
        s1_sel_d   = accept ? in_sel_i : s1_sel_q;
        s2_data_d  = adv2 ? lookup : s2_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_data_q <= '0;
            s1_sel_q  <= '0;
            s2_data_q <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_data_q <= s1_data_d;
            s1_sel_q  <= s1_sel_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign out_valid_o = v2_q;
    assign out_data_o  = s2_data_q;
    assign occupancy_o = {1'b0, v1_q} + {1'b0, v2_q};
endmodule

// File: tb/tb_clefia_sbox_layer.sv
// Bench for clefia_sbox_layer (LANES=4): spec vectors, streaming, backpressure and reset flush.
`timescale 1ns/1ps

module tb_clefia_sbox_layer;
    logic        clk_i = 1'b0;
    logic        rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0] in_data_i, out_data_o;
    logic [3:0]  in_sel_i;
    logic [1:0]  occupancy_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    clefia_sbox_layer #(.LANES(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_sel_i    (in_sel_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    localparam logic [3:0] R_SS0 [16] = '{4'hE, 4'h6, 4'hC, 4'hA, 4'h8, 4'h7, 4'h2, 4'hF,
                                         4'hB, 4'h1, 4'h4, 4'h0, 4'h5, 4'h9, 4'hD, 4'h3};
    localparam logic [3:0] R_SS1 [16] = '{4'h6, 4'h4, 4'h0, 4'hD, 4'h2, 4'hB, 4'hA, 4'h3,
                                         4'h9, 4'hC, 4'hE, 4'hF, 4'h8, 4'h7, 4'h5, 4'h1};
    localparam logic [3:0] R_SS2 [16] = '{4'hB, 4'h8, 4'h5, 4'hE, 4'hA, 4'h6, 4'h4, 4'hC,
                                         4'hF, 4'h7, 4'h2, 4'h3, 4'h1, 4'h0, 4'hD, 4'h9};
    localparam logic [3:0] R_SS3 [16] = '{4'hA, 4'h2, 4'h6, 4'hD, 4'h3, 4'h4, 4'h5, 4'hE,
                                         4'h0, 4'h7, 4'h8, 4'h9, 4'hB, 4'hF, 4'hC, 4'h1};
    localparam logic [7:0] R_S1 [256] = '{
        8'h6c, 8'hda, 8'hc3, 8'he9, 8'h4e, 8'h9d, 8'h0a, 8'h3d, 8'hb8, 8'h36, 8'hb4, 8'h38, 8'h13, 8'h34, 8'h0c, 8'hd9,
        8'hbf, 8'h74, 8'h94, 8'h8f, 8'hb7, 8'h9c, 8'he5, 8'hdc, 8'h9e, 8'h07, 8'h49, 8'h4f, 8'h98, 8'h2c, 8'hb0, 8'h93,
        8'h12, 8'heb, 8'hcd, 8'hb3, 8'h92, 8'he7, 8'h41, 8'h60, 8'he3, 8'h21, 8'h27, 8'h3b, 8'he6, 8'h19, 8'hd2, 8'h0e,
        8'h91, 8'h11, 8'hc7, 8'h3f, 8'h2a, 8'h8e, 8'ha1, 8'hbc, 8'h2b, 8'hc8, 8'hc5, 8'h0f, 8'h5b, 8'hf3, 8'h87, 8'h8b,
        8'hfb, 8'hf5, 8'hde, 8'h20, 8'hc6, 8'ha7, 8'h84, 8'hce, 8'hd8, 8'h65, 8'h51, 8'hc9, 8'ha4, 8'hef, 8'h43, 8'h53,
        8'h25, 8'h5d, 8'h9b, 8'h31, 8'he8, 8'h3e, 8'h0d, 8'hd7, 8'h80, 8'hff, 8'h69, 8'h8a, 8'hba, 8'h0b, 8'h73, 8'h5c,
        8'h6e, 8'h54, 8'h15, 8'h62, 8'hf6, 8'h35, 8'h30, 8'h52, 8'ha3, 8'h16, 8'hd3, 8'h28, 8'h32, 8'hfa, 8'haa, 8'h5e,
        8'hcf, 8'hea, 8'hed, 8'h78, 8'h33, 8'h58, 8'h09, 8'h7b, 8'h63, 8'hc0, 8'hc1, 8'h46, 8'h1e, 8'hdf, 8'ha9, 8'h99,
        8'h55, 8'h04, 8'hc4, 8'h86, 8'h39, 8'h77, 8'h82, 8'hec, 8'h40, 8'h18, 8'h90, 8'h97, 8'h59, 8'hdd, 8'h83, 8'h1f,
        8'h9a, 8'h37, 8'h06, 8'h24, 8'h64, 8'h7c, 8'ha5, 8'h56, 8'h48, 8'h08, 8'h85, 8'hd0, 8'h61, 8'h26, 8'hca, 8'h6f,
        8'h7e, 8'h6a, 8'hb6, 8'h71, 8'ha0, 8'h70, 8'h05, 8'hd1, 8'h45, 8'h8c, 8'h23, 8'h1c, 8'hf0, 8'hee, 8'h89, 8'had,
        8'h7a, 8'h4b, 8'hc2, 8'h2f, 8'hdb, 8'h5a, 8'h4d, 8'h76, 8'h67, 8'h17, 8'h2d, 8'hf4, 8'hcb, 8'hb1, 8'h4a, 8'ha8,
        8'hb5, 8'h22, 8'h47, 8'h3a, 8'hd5, 8'h10, 8'h4c, 8'h72, 8'hcc, 8'h00, 8'hf9, 8'he0, 8'hfd, 8'he2, 8'hfe, 8'hae,
        8'hf8, 8'h5f, 8'hab, 8'hf1, 8'h1b, 8'h42, 8'h81, 8'hd6, 8'hbe, 8'h44, 8'h29, 8'ha6, 8'h57, 8'hb9, 8'haf, 8'hf2,
        8'hd4, 8'h75, 8'h66, 8'hbb, 8'h68, 8'h9f, 8'h50, 8'h02, 8'h01, 8'h3c, 8'h7f, 8'h8d, 8'h1a, 8'h88, 8'hbd, 8'hac,
        8'hf7, 8'he4, 8'h79, 8'h96, 8'ha2, 8'hfc, 8'h6d, 8'hb2, 8'h6b, 8'h03, 8'he1, 8'h2e, 8'h7d, 8'h14, 8'h95, 8'h1d
    };

    function automatic logic [3:0] gmul16(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p  = 4'h0;
        logic [3:0] aa = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ aa;
            aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_s0(input logic [7:0] x);
        logic [3:0] a = R_SS0[x[7:4]];
        logic [3:0] b = R_SS1[x[3:0]];
        return {R_SS2[a ^ gmul16(4'h2, b)], R_SS3[gmul16(4'h2, a) ^ b]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = '0;
        for (int l = 0; l < 4; l++)
            r[8*l +: 8] = s[l] ? R_S1[d[8*l +: 8]] : ref_s0(d[8*l +: 8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk_i) begin
        if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no output", out_data_o);
            end else begin
                check("sb_data", out_data_o, sb_q.pop_front());
            end
        end
        if (in_valid_i === 1'b1 && in_ready_o === 1'b1)
            sb_q.push_back(ref_word(in_data_i, in_sel_i));
        if (rst_i === 1'b1)
            sb_q.delete();
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_single(input logic [31:0] d, input logic [3:0] s, input logic [31:0] e);
        next_cycle();
        in_valid_i = 1'b1; in_data_i = d; in_sel_i = s; out_ready_i = 1'b1;
        @(negedge clk_i);
        check("single_in_ready", in_ready_o, 1);
        next_cycle();
        in_valid_i = 1'b0; in_data_i = $urandom;
        @(negedge clk_i);
        check("single_lat1_valid", out_valid_o, 0);
        next_cycle();
        @(negedge clk_i);
        check("single_lat2_valid", out_valid_o, 1);
        check("single_data", out_data_o, e);
        next_cycle();
        @(negedge clk_i);
        check("single_one_cycle", out_valid_o, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0010FFC9, 4'b1111, 32'h6CBF1D00};
        vecs[1] = '{32'h00000101, 4'b0101, 32'h576C49DA};
        vecs[2] = '{32'h00000000, 4'b0000, 32'h57575757};
        vecs[3] = '{32'h01010101, 4'b1111, 32'hDADADADA};
        vecs[4] = '{32'hC9C9C9C9, 4'b1111, 32'h00000000};
        vecs[5] = '{32'h01000100, 4'b1010, 32'hDA57DA57};

        rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDEADBEEF; in_sel_i = 4'hF; out_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk_i);
            check("rst_out_valid", out_valid_o, 0);
            check("rst_occupancy", occupancy_o, 0);
            check("rst_in_ready", in_ready_o, 0);
        end
        next_cycle();
        rst_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_in_ready", in_ready_o, 1);
        check("post_rst_out_data", out_data_o, 0);

        for (int v = 0; v < 6; v++)
            send_single(vecs[v].data, vecs[v].sel, vecs[v].exp);

        // Streaming: 256 back-to-back words, no bubbles after the fill.
        for (int i = 0; i < 258; i++) begin
            next_cycle();
            out_ready_i = 1'b1;
            if (i < 256) begin
                in_valid_i = 1'b1; in_data_i = {4{8'(i)}}; in_sel_i = 4'b1010;
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (i < 256) check("stream_in_ready", in_ready_o, 1);
            if (i >= 2) check("stream_no_bubble", out_valid_o, 1);
        end
        next_cycle();
        @(negedge clk_i);
        check("stream_drained", out_valid_o, 0);

        // Backpressure: A, B fill the pipe, C is held by the source.
        next_cycle();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h11223344; in_sel_i = 4'b0101;
        @(negedge clk_i);
        check("bp_a_ready", in_ready_o, 1);
        next_cycle();
        in_data_i = 32'h55667788; in_sel_i = 4'b1010;
        @(negedge clk_i);
        check("bp_b_ready", in_ready_o, 1);
        next_cycle();
        in_data_i = 32'h99AABBCC; in_sel_i = 4'b0011;
        @(negedge clk_i);
        check("bp_full_ready", in_ready_o, 0);
        check("bp_full_occ", occupancy_o, 2);
        check("bp_hold_data0", out_data_o, ref_word(32'h11223344, 4'b0101));
        next_cycle();
        in_valid_i = 1'b0; in_data_i = 32'hFFFFFFFF; in_sel_i = 4'b1111;
        @(negedge clk_i);
        check("bp_hold_data1", out_data_o, ref_word(32'h11223344, 4'b0101));
        check("bp_hold_occ", occupancy_o, 2);
        next_cycle();
        in_valid_i = 1'b1; in_data_i = 32'h99AABBCC; in_sel_i = 4'b0011;
        @(negedge clk_i);
        check("bp_hold_data2", out_data_o, ref_word(32'h11223344, 4'b0101));
        next_cycle();
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", in_ready_o, 1);
        check("bp_out_a", out_data_o, ref_word(32'h11223344, 4'b0101));
        next_cycle();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_out_b", out_data_o, ref_word(32'h55667788, 4'b1010));
        check("bp_simul_occ", occupancy_o, 2);
        next_cycle();
        @(negedge clk_i);
        check("bp_out_c", out_data_o, ref_word(32'h99AABBCC, 4'b0011));
        check("bp_out_c_valid", out_valid_o, 1);
        next_cycle();
        out_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_empty_occ", occupancy_o, 0);

        // Reset mid-stream with a full pipeline.
        next_cycle();
        in_valid_i = 1'b1; in_data_i = 32'hA5A5A5A5; in_sel_i = 4'b1100;
        next_cycle();
        in_data_i = 32'h5A5A5A5A; in_sel_i = 4'b0110;
        next_cycle();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("mid_full_occ", occupancy_o, 2);
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_in_ready", in_ready_o, 0);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_out_valid", out_valid_o, 0);
        check("mid_occ", occupancy_o, 0);
        check("mid_out_data", out_data_o, 0);
        send_single(32'h01FF10C9, 4'b0110, ref_word(32'h01FF10C9, 4'b0110));

        next_cycle();
        @(negedge clk_i);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clefia_sbox_layer.md
# clefia_sbox_layer

Parametrised, pipelined CLEFIA S-box layer: applies S0 or S1, selected per byte lane, to a LANES-byte word under a valid/ready handshake. It replaces the bare combinational S0/S1 lookups in the F-function datapath. It sits between the round-key XOR and the M0/M1 diffusion stage, and instantiates the existing S0 and S1 byte tables once per lane.

## Interface
- LANES, 4, number of byte lanes (1..16); word width W = 8*LANES
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word and select are valid
- in_ready  out  1  layer accepts the input word this cycle
- in_data  in  W  lane i = in_data[8i+7:8i]
- in_sel  in  LANES  per-lane table select: 0 = S0, 1 = S1
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  W  substituted word, same lane ordering
- occupancy  out  2  number of words held in the pipeline (0..2)

## Operation
- Two register stages:
  - Stage 1 (S1R) captures in_data and in_sel.
  - Stage 2 (S2R) captures the per-lane lookup of the S1R contents.
  - The lookup is combinational between S1R and S2R.
- Lane function: out lane i = in_sel[i] ? S1(byte i) : S0(byte i), with the select captured alongside its own word.
- Mode patterns (LANES=4, lane 3 = MSB):
  - F0 uses sel = 4'b0101 (S0,S1,S0,S1 from MSB).
  - F1 uses sel = 4'b1010.
- Each stage holds a valid bit (v1, v2).
- Advance rules:
  - adv2 = v1 && (!v2 || out_ready)
  - in_ready = !rst && (!v1 || adv2)
  - S1R loads when in_valid && in_ready.
  - v1 next = (in_valid && in_ready) || (v1 && !adv2).
  - S2R loads on adv2. v2 next = adv2 || (v2 && !out_ready).
- out_valid = v2 and out_data = S2R data. out_data holds stable while out_valid && !out_ready.
- occupancy = v1 + v2 (registered bits summed combinationally).
- Simultaneous accept and emit when full (v1 = v2 = 1, out_ready = 1, in_valid = 1):
  - S2R takes the S1R lookup, S1R takes the new word.
  - Occupancy stays 2 and no bubble is inserted.
- No reordering and no dropping. Words emerge in acceptance order.
- Undefined table inputs do not exist: all 256 byte values map per the CLEFIA tables.

## Timing
- Reset, applied in any cycle including mid-stream:
  - On the next edge v1 = v2 = 0, out_valid = 0, out_data = 0, S1R data/sel = 0, occupancy = 0.
  - Words in flight are discarded.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- Latency: a word accepted at edge N is visible on out_data after edge N+2 (out_valid high in cycle N+2) if out_ready has been high.
- Throughput: one word per cycle with out_ready held high.
- Backpressure: with out_ready low, the pipeline fills to 2 words; in_ready then drops in the same cycle that v1 && v2 && !out_ready holds.
- in_ready depends combinationally on out_ready (one-level ready chain, no skid buffer). Upstream must not make in_valid depend on in_ready.
- in_valid may drop or the data may change at any time while in_ready is low; nothing is captured.

## Test plan
- Reset/idle:
  - Assert rst for 3 cycles with in_valid = 1 -> out_valid = 0, occupancy = 0, in_ready = 0 during reset.
  - in_ready = 1 on the first cycle after release.
- Single word, all S1 (LANES=4):
  - in_data = 32'h00_10_FF_C9, sel = 4'b1111, out_ready = 1 -> two cycles later out_data = 32'h6C_BF_1D_00, out_valid high for exactly one cycle.
- Mixed selects:
  - in_data = 32'h00_00_01_01, sel = 4'b0101 -> out_data = 32'h57_6C_49_DA (S0[00] = 57, S1[00] = 6C, S0[01] = 49, S1[01] = DA).
- Streaming:
  - Feed 256 back-to-back words, each byte = k (k = 0..255), sel = 4'b1010, out_ready = 1.
  - Required: in_ready stays 1, 256 outputs in order matching the reference tables, zero bubbles after the 2-cycle fill.
- Backpressure:
  - Send 3 words with out_ready = 0 -> occupancy reaches 2 and in_ready = 0; the third word is held by the source.
  - Raise out_ready for 3 cycles -> the three words emerge in order; the word on out_data never changes while out_valid && !out_ready.
- Reset mid-stream:
  - With occupancy = 2, assert rst for 1 cycle -> next cycle out_valid = 0, occupancy = 0, out_data = 0.
  - A fresh word afterwards emerges with normal 2-cycle latency, with no residue from the flushed words.
